// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: locks onto hsync/vsync, recovers pixel
// coordinates with a valid strobe, and reports timing errors and relock count.
module vga_sync_decoder #(
    parameter int H_WHOLE        = 1040,
    parameter int H_SYNC_PULSE   = 120,
    parameter int H_ACTIVE_START = 177,
    parameter int H_VISIBLE      = 800,
    parameter int V_WHOLE        = 666,
    parameter int V_SYNC_PULSE   = 6,
    parameter int V_ACTIVE_START = 43,
    parameter int V_VISIBLE      = 600
) (
    input  logic        clk50M,
    input  logic        rst_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [8:0]  color_in,
    input  logic        clr_err,
    output logic        pixel_valid,
    output logic [10:0] pixel_x,
    output logic [10:0] pixel_y,
    output logic [8:0]  pixel_color,
    output logic        frame_start,
    output logic        locked,
    output logic [3:0]  err_flags,
    output logic [7:0]  err_cnt
);

    localparam logic [10:0] L_H_WHOLE = 11'(H_WHOLE);
    localparam logic [10:0] L_H_SYNC  = 11'(H_SYNC_PULSE);
    localparam logic [10:0] L_H_ACT   = 11'(H_ACTIVE_START);
    localparam logic [10:0] L_H_END   = 11'(H_ACTIVE_START + H_VISIBLE);
    localparam logic [10:0] L_V_WHOLE = 11'(V_WHOLE);
    localparam logic [10:0] L_V_SYNC  = 11'(V_SYNC_PULSE);
    localparam logic [10:0] L_V_ACT   = 11'(V_ACTIVE_START);
    localparam logic [10:0] L_V_END   = 11'(V_ACTIVE_START + V_VISIBLE);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic        r_hs_q, r_vs_q, r_hs_d, r_vs_d, r_clr_q;
    logic [8:0]  r_col_q;

    state_t      r_state, w_state_nxt;
    logic [10:0] r_h_pos_p1, r_v_pos_p1;
    logic [8:0]  r_col_p1;
    logic        r_fail_p1;
    logic [3:0]  r_err_p1;
    logic [7:0]  r_err_cnt_p1;

    logic        w_h_fall, w_h_rise, w_v_fall, w_v_rise, w_frame_edge;
    logic [10:0] w_h_pos_inc, w_h_pos_nxt, w_v_pos_inc, w_v_pos_nxt;
    logic        w_chk_en;
    logic        w_err_hlen, w_err_hsync, w_err_vlen, w_err_vsync;
    logic [3:0]  w_set;
    logic        w_fail, w_cnt_inc;
    logic        w_win, w_pix_ok;

    // ---- stage 1: input capture and edge-detect delay ----
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            r_hs_q  <= 1'b1;
            r_vs_q  <= 1'b1;
            r_hs_d  <= 1'b1;
            r_vs_d  <= 1'b1;
            r_col_q <= 9'd0;
            r_clr_q <= 1'b0;
        end else begin
            r_hs_q  <= hsync;
            r_vs_q  <= vsync;
            r_hs_d  <= r_hs_q;
            r_vs_d  <= r_vs_q;
            r_col_q <= color_in;
            r_clr_q <= clr_err;
        end
    end

    assign w_h_fall     = r_hs_d & ~r_hs_q;
    assign w_h_rise     = ~r_hs_d & r_hs_q;
    assign w_v_fall     = r_vs_d & ~r_vs_q;
    assign w_v_rise     = ~r_vs_d & r_vs_q;
    assign w_frame_edge = w_v_fall & w_h_fall;

    assign w_h_pos_inc = sat_inc11(r_h_pos_p1);
    assign w_h_pos_nxt = w_h_fall ? 11'd0 : w_h_pos_inc;
    assign w_v_pos_inc = sat_inc11(r_v_pos_p1);
    assign w_v_pos_nxt = w_frame_edge ? 11'd0 : (w_h_fall ? w_v_pos_inc : r_v_pos_p1);

    // Checks compare against the counter value of the previous sample.
    assign w_chk_en    = (r_state != ST_UNLOCKED);
    assign w_err_hlen  = w_chk_en & (w_h_fall ? (w_h_pos_inc != L_H_WHOLE)
                                              : (w_h_pos_inc == L_H_WHOLE));
    assign w_err_hsync = w_chk_en & w_h_rise & (w_h_pos_nxt != L_H_SYNC);
    assign w_err_vlen  = w_chk_en & (w_v_fall ? (w_v_pos_inc != L_V_WHOLE)
                                              : (w_h_fall & (w_v_pos_inc == L_V_WHOLE)));
    assign w_err_vsync = w_chk_en & (((w_v_fall | w_v_rise) & ~w_h_fall)
                                   | (w_v_rise & w_h_fall & (w_v_pos_inc != L_V_SYNC)));
    assign w_set  = {w_err_vsync, w_err_vlen, w_err_hsync, w_err_hlen};
    assign w_fail = |w_set;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_inc   = 1'b0;
        case (r_state)
            ST_UNLOCKED: begin
                if (w_frame_edge) w_state_nxt = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
                if (w_fail)            w_state_nxt = ST_UNLOCKED;
                else if (w_frame_edge) w_state_nxt = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (w_fail) begin
                    w_state_nxt = ST_UNLOCKED;
                    w_cnt_inc   = 1'b1;
                end
            end
            default: w_state_nxt = ST_UNLOCKED;
        endcase
    end

    // ---- stage 2: position counters, lock state, error accumulation ----
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_UNLOCKED;
            r_h_pos_p1   <= 11'd0;
            r_v_pos_p1   <= 11'd0;
            r_col_p1     <= 9'd0;
            r_fail_p1    <= 1'b0;
            r_err_p1     <= 4'd0;
            r_err_cnt_p1 <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_h_pos_p1 <= w_h_pos_nxt;
            r_v_pos_p1 <= w_v_pos_nxt;
            r_col_p1   <= r_col_q;
            r_fail_p1  <= w_fail;
            // A new error wins over a simultaneous clear request.
            if (w_fail)       r_err_p1 <= r_err_p1 | w_set;
            else if (r_clr_q) r_err_p1 <= 4'd0;
            if (w_cnt_inc)    r_err_cnt_p1 <= sat_inc8(r_err_cnt_p1);
        end
    end

    assign w_win    = (r_h_pos_p1 >= L_H_ACT) & (r_h_pos_p1 < L_H_END)
                    & (r_v_pos_p1 >= L_V_ACT) & (r_v_pos_p1 < L_V_END);
    assign w_pix_ok = w_win & (r_state == ST_LOCKED) & ~r_fail_p1;

    // ---- stage 3: registered outputs ----
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            pixel_valid <= 1'b0;
            pixel_x     <= 11'd0;
            pixel_y     <= 11'd0;
            pixel_color <= 9'd0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            err_flags   <= 4'd0;
            err_cnt     <= 8'd0;
        end else begin
            pixel_valid <= w_pix_ok;
            frame_start <= w_pix_ok & (r_h_pos_p1 == L_H_ACT) & (r_v_pos_p1 == L_V_ACT);
            if (w_pix_ok) begin
                pixel_x     <= r_h_pos_p1 - L_H_ACT;
                pixel_y     <= r_v_pos_p1 - L_V_ACT;
                pixel_color <= r_col_p1;
            end
            locked    <= (r_state == ST_LOCKED);
            err_flags <= r_err_p1;
            err_cnt   <= r_err_cnt_p1;
        end
    end

endmodule
